// File: rtl/fir_pkg.sv
// Shared constants and helpers for the FIR datapath and the stages that reuse it.
package fir_pkg;

    localparam int unsigned TAPS_DEF      = 4;
    localparam int unsigned DATA_W_DEF    = 16;
    localparam int unsigned COEFF_W_DEF   = 16;
    localparam int unsigned OUT_SHIFT_DEF = 0;

    // Edges from sample acceptance (E0) to the result register (E3).
    localparam int unsigned FIR_LATENCY = 3;

    localparam logic signed [DATA_W_DEF-1:0] SAT_MAX = {1'b0, {(DATA_W_DEF - 1){1'b1}}};
    localparam logic signed [DATA_W_DEF-1:0] SAT_MIN = {1'b1, {(DATA_W_DEF - 1){1'b0}}};

    function automatic int unsigned acc_w(input int unsigned data_w,
                                          input int unsigned coeff_w,
                                          input int unsigned taps);
        return data_w + coeff_w + $clog2(taps);
    endfunction

endpackage

// File: rtl/fir_sat_shift.sv
// Combinational arithmetic right shift followed by saturation to the output word width.
module fir_sat_shift
    import fir_pkg::*;
#(
    parameter int unsigned ACC_W     = acc_w(DATA_W_DEF, COEFF_W_DEF, TAPS_DEF),
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned OUT_SHIFT = OUT_SHIFT_DEF
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DATA_W-1:0] sat_out
);

    // Output limits sign-extended to the accumulator width for a signed compare.
    localparam logic signed [ACC_W-1:0] ACC_MAX =
        {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN =
        {{(ACC_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};
    localparam logic signed [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W - 1){1'b1}}};
    localparam logic signed [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W - 1){1'b0}}};

    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        shifted = acc >>> OUT_SHIFT;
        if (shifted > ACC_MAX) begin
            sat_out = OUT_MAX;
        end else if (shifted < ACC_MIN) begin
            sat_out = OUT_MIN;
        end else begin
            sat_out = shifted[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/fir_pipe.sv
// Pipelined direct-form FIR: delay line, per-tap products, adder, shift+saturate output.
module fir_pipe
    import fir_pkg::*;
#(
    parameter int unsigned TAPS      = TAPS_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned COEFF_W   = COEFF_W_DEF,
    parameter int unsigned OUT_SHIFT = OUT_SHIFT_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic                      valid_in,
    input  logic [TAPS*COEFF_W-1:0]   coeff_in,
    input  logic [DATA_W-1:0]         signal_in,
    output logic                      valid_out,
    output logic [DATA_W-1:0]         signal_out
);

    localparam int unsigned PROD_W = DATA_W + COEFF_W;
    localparam int unsigned ACC_W  = acc_w(DATA_W, COEFF_W, TAPS);

    if (TAPS < 2 || TAPS > 8) begin : g_taps_check
        $error("fir_pipe: TAPS must be in 2..8");
    end

    logic signed [DATA_W-1:0]  x_q   [TAPS];
    logic signed [COEFF_W-1:0] h_q   [TAPS];
    logic signed [PROD_W-1:0]  p_q   [TAPS];
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [DATA_W-1:0]  out_q, sat_res;
    // Bit s set means stage E(s) captured a sample at the last edge.
    logic [FIR_LATENCY:0]      vld_q;

    always_comb begin
        acc_d = '0;
        for (int unsigned k = 0; k < TAPS; k++) begin
            acc_d = acc_d + ACC_W'(p_q[k]);
        end
    end

    fir_sat_shift #(
        .ACC_W     (ACC_W),
        .DATA_W    (DATA_W),
        .OUT_SHIFT (OUT_SHIFT)
    ) u_sat (
        .acc     (acc_q),
        .sat_out (sat_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < TAPS; k++) begin
                x_q[k] <= '0;
                h_q[k] <= '0;
                p_q[k] <= '0;
            end
            acc_q <= '0;
            out_q <= '0;
            vld_q <= '0;
        end else begin
            if (load) begin
                for (int unsigned k = 0; k < TAPS; k++) begin
                    h_q[k] <= coeff_in[k*COEFF_W +: COEFF_W];
                end
            end
            // Idle cycles leave the delay line untouched.
            if (valid_in) begin
                x_q[0] <= signal_in;
                for (int unsigned k = 1; k < TAPS; k++) begin
                    x_q[k] <= x_q[k-1];
                end
            end
            if (vld_q[0]) begin
                for (int unsigned k = 0; k < TAPS; k++) begin
                    p_q[k] <= PROD_W'(x_q[k]) * PROD_W'(h_q[k]);
                end
            end
            if (vld_q[1]) begin
                acc_q <= acc_d;
            end
            if (vld_q[2]) begin
                out_q <= sat_res;
            end
            vld_q <= {vld_q[FIR_LATENCY-1:0], valid_in};
        end
    end

    assign valid_out  = vld_q[FIR_LATENCY];
    assign signal_out = out_q;

endmodule

// File: doc/fir_pipe.md
Name: fir_pipe

Overview:
- Pipelined N-tap direct-form FIR core that sits directly downstream of the PIO wrapper's input path.
- Consumes the wrapper's `fir_valid_in` / `fir_data_in` stream and produces `valid_out` / `signal_out` words for the output FIFO.
- Port-compatible replacement for the existing FIR instance: fixed latency, one sample per cycle, saturating signed arithmetic.

Parameters:
- TAPS, 4, number of taps; legal range 2..8.
- DATA_W, 16, signed sample width, in and out.
- COEFF_W, 16, signed coefficient width.
- OUT_SHIFT, 0, arithmetic right shift applied to the accumulator before saturation.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- load  input  1  when 1, coefficient register captures coeff_in at this edge.
- valid_in  input  1  signal_in carries a new sample this cycle.
- coeff_in  input  TAPS*COEFF_W  slice k = coeff_in[k*COEFF_W +: COEFF_W] is h[k], applied to x[n-k].
- signal_in  input  DATA_W  signed sample.
- valid_out  output  1  one-cycle strobe: signal_out holds a new result.
- signal_out  output  DATA_W  signed, saturated filter output.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset (rst=1 at an edge):
  - delay line x[0..TAPS-1], coefficient register, all pipeline registers and all valid bits clear to 0.
  - valid_out=0 and signal_out=0 from the following cycle.
  - Reset mid-stream discards in-flight samples; no result strobes for them.
- Coefficients: captured on every edge with load=1, legal while streaming. Stage E1 uses the register contents at that edge, which includes a load at the previous edge.
- Pipeline, for a sample accepted at edge T (valid_in=1):
  - E0 (edge T): x[k] <= x[k-1] for k>0, and x[0] <= signal_in.
  - E1 (edge T+1): p[k] <= x[k]*h[k], full-width signed, DATA_W+COEFF_W bits.
  - E2 (edge T+2): acc <= sum of p[k], ACC_W = DATA_W+COEFF_W+clog2(TAPS), sign-extended.
  - E3 (edge T+3): signal_out <= sat(acc >>> OUT_SHIFT); valid_out=1 for exactly the cycle after edge T+3.
- Latency: fixed at 3 edges, independent of TAPS.
- Throughput: 1 sample per cycle; back-to-back valid_in is supported with no stalls and no backpressure.
- Bubbles: valid_in=0 does not shift the delay line. A valid bit travels with each stage, so gaps in the input produce identical gaps in valid_out.
- Shift: arithmetic, truncating toward minus infinity.
- Saturation limits: results above 2^(DATA_W-1)-1 become 0x7FFF; results below -2^(DATA_W-1) become 0x8000 (DATA_W=16).
- Hold: signal_out holds its last value while valid_out=0.
- No internal state machine beyond the valid shift chain; the core has no idle/busy distinction, and the wrapper's fifo_full & ~valid_out test relies on valid_out fully reflecting in-flight work.
- Simultaneous events:
  - load and valid_in at the same edge: that sample uses the new coefficients.
  - rst with valid_in: rst wins and the sample is dropped.

Decomposition:
- Shared package fir_pkg: DATA_W/COEFF_W/TAPS defaults, FIR_LATENCY=3, ACC_W function, saturation limit constants SAT_MAX/SAT_MIN.
- One sub-module: fir_sat_shift, parameterised by ACC_W, DATA_W and OUT_SHIFT. It is combinational shift+saturate and feeds the E3 register; it is reused by future decimator stages.

Test Plan:
- Impulse: coeff_in={7,6,7,2}, load=1; valid_in back-to-back with 1,0,0,0,0,0 -> valid_out on 6 consecutive cycles starting 3 edges after the first sample, signal_out=2,7,6,7,0,0.
- Step: same coefficients, five samples of 1 -> 2,9,15,22,22.
- Saturation: coefficients all 7; inputs 0x7FFF x4 then 0x8000 x4 -> outputs reach and hold 0x7FFF, then reach and hold 0x8000 (saturated, never wrapped).
- Bubbles: samples 1,1 separated by 5 idle cycles with coeffs {7,6,7,2} -> exactly two strobes, values 2 then 9, spaced 6 cycles apart; the idle cycles do not shift zeros into the delay line.
- Reset mid-stream: assert rst for 1 cycle one edge after a sample is accepted -> no strobe for that sample. Next sample 1 -> output 0 (coefficients cleared). Reload {7,6,7,2} and send impulse -> 2,7,6,7.
- Coefficient swap: stream 1s, change coeff_in to {0,0,0,1} with a one-cycle load between samples -> the first sample after the load yields 1; earlier in-flight samples still use the old coefficients.
